mm_inst_issue: RTL and testbench



---
 rtl/mm_pkg.sv | 42 ++++
 rtl/mm_inst_issue_if.sv | 31 +++
 rtl/mm_inst_fifo.sv | 58 +++++
 rtl/mm_inst_issue.sv | 132 +++++++++++++
 tb/tb_mm_inst_issue.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mm_pkg.sv
// Shared definitions for the MM instruction issue path: instruction width,
// bit positions of the buffer-select and option flags, operand field ranges,
// and the issue FSM state type.
package mm_pkg;

    localparam int MM_INST_BIT_WIDTH = 128;

    // Single-bit selects and options.
    localparam int SRC_1A = 1;
    localparam int SRC_1B = 2;
    localparam int SRC_2A = 3;
    localparam int SRC_2B = 4;
    localparam int DST_2A = 9;
    localparam int DST_2B = 10;
    localparam int RELU   = 12;
    localparam int ACC    = 13;
    localparam int BIAS   = 14;

    // Multi-bit fields as [MSB:LSB].
    localparam int W_START_MSB   = 44;
    localparam int W_START_LSB   = 32;
    localparam int B_START_MSB   = 56;
    localparam int B_START_LSB   = 48;
    localparam int IN_START_MSB  = 74;
    localparam int IN_START_LSB  = 64;
    localparam int CO_MSB        = 87;
    localparam int CO_LSB        = 80;
    localparam int CI_MSB        = 95;
    localparam int CI_LSB        = 88;
    localparam int OUT_START_MSB = 106;
    localparam int OUT_START_LSB = 96;
    localparam int N_MSB         = 127;
    localparam int N_LSB         = 112;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RETIRE = 2'd3
    } issue_state_t;

endpackage

// File: rtl/mm_inst_issue_if.sv
// Handshake/bus bundle between dispatcher, issue stage and mm wrapper.
// Ports: instruction valid/ready/data in, ctrl_instruction + ap_start/ap_done to mm,
// done pulse/count, sticky error with clear, busy. slave = issue stage, master = environment.
interface mm_inst_issue_if #(
    parameter int W         = 128,
    parameter int CNT_WIDTH = 16
);
    logic                 inst_valid;
    logic                 inst_ready;
    logic [W-1:0]         inst_data;
    logic [W-1:0]         ctrl_instruction;
    logic                 ap_start;
    logic                 ap_done;
    logic                 done_valid;
    logic [CNT_WIDTH-1:0] done_count;
    logic                 err_illegal;
    logic                 err_clear;
    logic                 busy;

    modport slave (
        input  inst_valid, inst_data, ap_done, err_clear,
        output inst_ready, ctrl_instruction, ap_start, done_valid, done_count,
               err_illegal, busy
    );

    modport master (
        output inst_valid, inst_data, ap_done, err_clear,
        input  inst_ready, ctrl_instruction, ap_start, done_valid, done_count,
               err_illegal, busy
    );
endinterface

// File: rtl/mm_inst_fifo.sv
// Synchronous FIFO holding queued instructions (no bypass).
// Latency: a pushed word is visible at pop_data the cycle after the push.
// Backpressure: full blocks pushes, empty blocks pops; push+pop together keeps occupancy.
// Ports: clk/rst, push/push_data, pop/pop_data, full, empty.
module mm_inst_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage needs no reset: empty gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/mm_inst_issue.sv
// Issue stage: queues MM instructions, screens buffer selects, starts mm and retires on ap_done.
// Latency: push at edge t -> ap_start during cycle t+2; ap_done at d -> done_valid at d+1.
// Backpressure: inst_ready drops when the FIFO is full; one instruction in flight at a time.
// Ports: kernel_clk, kernel_rst (async, active-high), io (mm_inst_issue_if.slave).
module mm_inst_issue
    import mm_pkg::*;
#(
    parameter int INST_W     = MM_INST_BIT_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic            kernel_clk,
    input  logic            kernel_rst,
    mm_inst_issue_if.slave  io
);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [INST_W-1:0] pop_data;

    issue_state_t         state;
    logic [INST_W-1:0]    ctrl_q;
    logic                 legal_q;
    logic                 noop_q;
    logic                 start_q;
    logic                 done_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 err_q;
    logic                 busy_q;

    logic [3:0] src;
    logic [1:0] dst;
    logic       legal;
    logic       noop;

    assign fifo_pop = (state == ST_IDLE) && !fifo_empty;

    mm_inst_fifo #(
        .WIDTH (INST_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (kernel_clk),
        .rst       (kernel_rst),
        .push      (io.inst_valid),
        .push_data (io.inst_data),
        .pop       (fifo_pop),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Screening of the word at the FIFO head; only consumed when it is popped.
    always_comb begin
        src   = pop_data[SRC_2B:SRC_1A];
        dst   = pop_data[DST_2B:DST_2A];
        legal = $onehot(src) && $onehot(dst)
             && !(pop_data[SRC_2A] && pop_data[DST_2A])
             && !(pop_data[SRC_2B] && pop_data[DST_2B])
             && (pop_data[CI_MSB:CI_LSB] != '0)
             && (pop_data[CO_MSB:CO_LSB] != '0);
        noop  = (pop_data[N_MSB:N_LSB] == '0);
    end

    always_ff @(posedge kernel_clk or posedge kernel_rst) begin
        if (kernel_rst) begin
            state   <= ST_IDLE;
            ctrl_q  <= '0;
            legal_q <= 1'b0;
            noop_q  <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= !fifo_empty || (state != ST_IDLE);

            // Placed ahead of the FSM so an illegal-word set in ISSUE overrides it.
            if (io.err_clear) begin
                err_q <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        ctrl_q  <= pop_data;
                        legal_q <= legal;
                        noop_q  <= noop;
                        // Start is raised on entry so it is high for the whole ISSUE cycle.
                        start_q <= legal && !noop;
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!legal_q) begin
                        err_q <= 1'b1;
                        state <= ST_IDLE;
                    end else if (noop_q || io.ap_done) begin
                        done_q <= 1'b1;
                        cnt_q  <= cnt_q + CNT_ONE;
                        state  <= ST_RETIRE;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (io.ap_done) begin
                        done_q <= 1'b1;
                        cnt_q  <= cnt_q + CNT_ONE;
                        state  <= ST_RETIRE;
                    end
                end
                ST_RETIRE: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign io.inst_ready       = !fifo_full;
    assign io.ctrl_instruction = ctrl_q;
    assign io.ap_start         = start_q;
    assign io.done_valid       = done_q;
    assign io.done_count       = cnt_q;
    assign io.err_illegal      = err_q;
    assign io.busy             = busy_q;
endmodule

// File: tb/tb_mm_inst_issue.sv
// Testbench for mm_inst_issue: directed scenarios plus randomized traffic.
// A reference model classifies each accepted word and queues the expected
// starts/retirements; a negedge monitor pops and compares as the DUT reports them.
module tb_mm_inst_issue;
    localparam int W  = 128;
    localparam int CW = 16;

    logic kernel_clk = 1'b0;
    logic kernel_rst = 1'b1;

    mm_inst_issue_if #(.W(W), .CNT_WIDTH(CW)) bus ();

    mm_inst_issue #(.INST_W(W), .FIFO_DEPTH(4), .CNT_WIDTH(CW)) dut (
        .kernel_clk (kernel_clk),
        .kernel_rst (kernel_rst),
        .io         (bus)
    );

    always #5 kernel_clk = ~kernel_clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge kernel_clk) cyc++;

    // Reference model state
    logic [W-1:0] start_q [$];
    int           start_cyc_q [$];
    logic [W-1:0] retire_q [$];
    int           exp_cnt   = 0;
    int           n_illegal = 0;

    // Monitor state
    bit outstanding      = 0;
    bit expect_done_next = 0;
    bit prev_start       = 0;
    int last_done_cyc    = -100;

    // Responder state
    bit resp_auto = 0;
    bit spur_en   = 0;
    int cd        = 0;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // 0 = illegal, 1 = legal no-op, 2 = legal runnable
    function automatic int classify(input logic [W-1:0] w);
        int nsrc;
        int ndst;
        nsrc = 0;
        for (int i = 1; i <= 4; i++) nsrc += int'(w[i]);
        ndst = int'(w[9]) + int'(w[10]);
        if (nsrc != 1 || ndst != 1) return 0;
        if ((w[3] && w[9]) || (w[4] && w[10])) return 0;
        if (w[95:88] == 8'd0 || w[87:80] == 8'd0) return 0;
        return (w[127:112] == 16'd0) ? 1 : 2;
    endfunction

    function automatic logic [W-1:0] mk(input int sb, input int db, input logic [7:0] ci,
                                        input logic [7:0] co, input logic [15:0] n);
        logic [W-1:0] w;
        w = '0;
        w[sb] = 1'b1;
        w[db] = 1'b1;
        w[95:88]   = ci;
        w[87:80]   = co;
        w[127:112] = n;
        w[44:32]   = 13'($urandom);
        return w;
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        w = {$urandom, $urandom, $urandom, $urandom};
        w[4:1]  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
        w[10:9] = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'(1 << $urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) w[95:88] = 8'd0;
        if ($urandom_range(0, 7) == 0) w[87:80] = 8'd0;
        if ($urandom_range(0, 4) == 0) w[127:112] = 16'd0;
        return w;
    endfunction

    task automatic model_push(input logic [W-1:0] w, input int t);
        int c;
        c = classify(w);
        if (c == 2) begin
            start_q.push_back(w);
            start_cyc_q.push_back(t);
        end
        if (c >= 1) retire_q.push_back(w);
        if (c == 0) n_illegal++;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push_word(input logic [W-1:0] w, output int t0);
        int waited;
        waited = 0;
        bus.inst_valid = 1'b1;
        bus.inst_data  = w;
        while (!bus.inst_ready && waited < 300) begin
            @(negedge kernel_clk);
            waited++;
        end
        check("push_accept", bus.inst_ready, 1);
        t0 = cyc;
        if (bus.inst_ready) model_push(w, cyc);
        @(negedge kernel_clk);
        bus.inst_valid = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge kernel_clk);
    endtask

    task automatic pulse_done();
        @(posedge kernel_clk);
        #1 bus.ap_done = 1'b1;
        @(posedge kernel_clk);
        #1 bus.ap_done = 1'b0;
    endtask

    task automatic drain();
        int quiet;
        int n;
        quiet = 0;
        n = 0;
        while (quiet < 3 && n < 3000) begin
            @(negedge kernel_clk);
            n++;
            if (start_q.size() == 0 && retire_q.size() == 0 && !outstanding && !bus.busy) quiet++;
            else quiet = 0;
        end
        check("drain_done", (quiet >= 3), 1);
    endtask

    // Monitor: pops expectations whenever the DUT reports a start or a retirement.
    always @(negedge kernel_clk) begin
        if (!kernel_rst) begin
            if (bus.ap_start) begin
                check("start_expected", (start_q.size() != 0), 1);
                check("start_single_cycle", prev_start, 0);
                if (start_q.size() != 0) begin
                    logic [W-1:0] e;
                    int pc;
                    e  = start_q.pop_front();
                    pc = start_cyc_q.pop_front();
                    check("start_word", bus.ctrl_instruction, e);
                    check("start_latency_min", (cyc >= pc + 2), 1);
                    check("start_gap_after_done", (cyc >= last_done_cyc + 3), 1);
                end
                outstanding = 1;
            end
            if (expect_done_next) begin
                check("done_latency", bus.done_valid, 1);
                expect_done_next = 0;
            end
            if (bus.ap_done && outstanding) begin
                outstanding      = 0;
                expect_done_next = 1;
                last_done_cyc    = cyc;
            end
            if (bus.done_valid) begin
                outstanding = 0;
                check("done_expected", (retire_q.size() != 0), 1);
                if (retire_q.size() != 0) begin
                    logic [W-1:0] e;
                    e = retire_q.pop_front();
                    exp_cnt++;
                    check("retire_word", bus.ctrl_instruction, e);
                    check("done_count", bus.done_count, W'(CW'(exp_cnt)));
                end
            end
            prev_start = bus.ap_start;
        end
    end

    // Auto responder: answers each ap_start after 0..5 cycles, with occasional stray pulses.
    initial begin
        forever begin
            @(posedge kernel_clk);
            #1;
            if (resp_auto) begin
                bus.ap_done = 1'b0;
                if (bus.ap_start) begin
                    if ($urandom_range(0, 3) == 0) bus.ap_done = 1'b1;
                    else cd = $urandom_range(1, 5);
                end else if (cd > 0) begin
                    cd--;
                    if (cd == 0) bus.ap_done = 1'b1;
                end else if (spur_en && $urandom_range(0, 19) == 0) begin
                    bus.ap_done = 1'b1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        logic [W-1:0] w1;
        logic [W-1:0] wt;
        int t0;
        int tdummy;

        bus.inst_valid = 1'b0;
        bus.inst_data  = '0;
        bus.ap_done    = 1'b0;
        bus.err_clear  = 1'b0;

        // Reset state
        ticks(3);
        check("rst_inst_ready", bus.inst_ready, 1);
        check("rst_ap_start", bus.ap_start, 0);
        check("rst_ctrl", bus.ctrl_instruction, 0);
        check("rst_done_count", bus.done_count, 0);
        check("rst_err", bus.err_illegal, 0);
        check("rst_busy", bus.busy, 0);
        kernel_rst = 1'b0;
        ticks(2);

        // Single legal instruction, ap_done 20 cycles after the push cycle
        w1 = mk(1, 9, 8'd4, 8'd8, 16'd16);
        push_word(w1, t0);
        check("t1_no_start_early", bus.ap_start, 0);
        ticks(1);
        check("t1_start_cycle", bus.ap_start, 1);
        check("t1_ctrl", bus.ctrl_instruction, w1);
        ticks(1);
        check("t1_start_drop", bus.ap_start, 0);
        check("t1_busy", bus.busy, 1);
        while (cyc < t0 + 20) @(negedge kernel_clk);
        bus.ap_done = 1'b1;
        ticks(1);
        bus.ap_done = 1'b0;
        check("t1_done_valid", bus.done_valid, 1);
        check("t1_count", bus.done_count, 1);
        ticks(3);
        check("t1_ctrl_hold", bus.ctrl_instruction, w1);
        check("t1_done_drop", bus.done_valid, 0);

        // Five back-to-back pushes with ap_done withheld
        for (int i = 0; i < 5; i++) push_word(mk(2, 10, 8'(i + 1), 8'd3, 16'(i + 7)), tdummy);
        check("five_full", bus.inst_ready, 0);
        for (int i = 0; i < 5; i++) begin
            ticks(3);
            pulse_done();
            ticks(3);
            check("five_slot_free", bus.inst_ready, 1);
        end
        drain();
        check("five_count", bus.done_count, 6);

        // Illegal words
        push_word(mk(1, 9, 8'd4, 8'd8, 16'd5) | (W'(1) << 2), tdummy);
        push_word(mk(3, 9, 8'd4, 8'd8, 16'd5), tdummy);
        push_word(mk(1, 9, 8'd0, 8'd8, 16'd5), tdummy);
        drain();
        check("illegal_err", bus.err_illegal, (n_illegal > 0));
        check("illegal_count", bus.done_count, 6);
        bus.err_clear = 1'b1;
        ticks(1);
        bus.err_clear = 1'b0;
        n_illegal = 0;
        check("err_cleared", bus.err_illegal, 0);

        // Set wins over a simultaneous clear
        bus.err_clear = 1'b1;
        push_word(mk(4, 10, 8'd1, 8'd1, 16'd1), t0);
        while (cyc < t0 + 3) @(negedge kernel_clk);
        check("err_set_wins", bus.err_illegal, 1);
        ticks(1);
        check("err_clear_next", bus.err_illegal, 0);
        bus.err_clear = 1'b0;
        n_illegal = 0;
        drain();

        // Legal no-op
        push_word(mk(2, 9, 8'd2, 8'd2, 16'd0), t0);
        while (cyc < t0 + 3) @(negedge kernel_clk);
        check("noop_done", bus.done_valid, 1);
        check("noop_count", bus.done_count, 7);
        drain();

        // ap_done in the ISSUE cycle
        push_word(mk(1, 10, 8'd9, 8'd9, 16'd3), t0);
        @(posedge kernel_clk);
        #1 bus.ap_done = 1'b1;
        @(posedge kernel_clk);
        #1 bus.ap_done = 1'b0;
        @(negedge kernel_clk);
        check("issue_done_retire", bus.done_valid, 1);
        drain();

        // Stray ap_done in IDLE
        pulse_done();
        ticks(3);
        check("spurious_count", bus.done_count, W'(CW'(exp_cnt)));
        check("spurious_busy", bus.busy, 0);

        // Randomized traffic
        resp_auto = 1;
        spur_en   = 1;
        for (int i = 0; i < 60; i++) begin
            push_word(rand_word(), tdummy);
            ticks($urandom_range(0, 3));
        end
        drain();
        check("rand_err", bus.err_illegal, (n_illegal > 0));
        check("rand_count", bus.done_count, W'(CW'(exp_cnt)));
        bus.err_clear = 1'b1;
        ticks(1);
        bus.err_clear = 1'b0;
        n_illegal = 0;
        resp_auto = 0;
        spur_en   = 0;
        ticks(2);
        bus.ap_done = 1'b0;

        // Asynchronous reset mid-WAIT with three words queued
        for (int i = 0; i < 4; i++) push_word(mk(1, 9, 8'd5, 8'd6, 16'(i + 1)), tdummy);
        ticks(4);
        check("pre_rst_busy", bus.busy, 1);
        #2 kernel_rst = 1'b1;
        #1;
        check("arst_ap_start", bus.ap_start, 0);
        check("arst_ctrl", bus.ctrl_instruction, 0);
        check("arst_count", bus.done_count, 0);
        check("arst_inst_ready", bus.inst_ready, 1);
        check("arst_busy", bus.busy, 0);
        start_q.delete();
        start_cyc_q.delete();
        retire_q.delete();
        exp_cnt          = 0;
        outstanding      = 0;
        expect_done_next = 0;
        prev_start       = 0;
        @(negedge kernel_clk);
        kernel_rst = 1'b0;
        pulse_done();
        ticks(6);
        check("post_rst_count", bus.done_count, 0);
        check("post_rst_ready", bus.inst_ready, 1);
        check("post_rst_busy", bus.busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
